fft_stage_ctrl: RTL and testbench

Sequencing controller for one radix-2 single-path delay-feedback stage built around the 16-lane `bfly` butterfly and its delay shift register. It runs each frame through three phases: fill the shift register, stream the butterfly, then drain the twiddled differences. It drives `bfly_en`, the shift-register enable and mux selects, the stage output mux and frame markers. One instance per FFT stage, between the upstream stage output and the next stage input.

---
 rtl/fft_stage_ctrl.sv | 79 +++++++
 tb/tb_fft_stage_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: FILL/BFLY/DRAIN sequencer for one radix-2 SDF stage around bfly and its delay line.
// Ports: clk, rstn (sync, active-low); din_valid/din_ready upstream handshake; sr_shift/sr_sel delay-line
// control; bfly_en/tw_addr butterfly enable and twiddle quarter; out_sel/dout_valid/sof/eof stage output;
// busy (not IDLE); err sticky underrun flag.
// Optional: define FFT_STAGE_CTRL_UNDERRUN_EN to abort a frame on a missing input beat during BFLY.
module fft_stage_ctrl #(
  parameter int DEPTH = 512,
  localparam int CW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       sr_shift,
  output logic       sr_sel,
  output logic       bfly_en,
  output logic [1:0] tw_addr,
  output logic       out_sel,
  output logic       dout_valid,
  output logic       sof,
  output logic       eof,
  output logic       busy,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic last, under, bfly_on, fill_in;
  assign last = cnt == CW'(DEPTH - 1);
`ifdef FFT_STAGE_CTRL_UNDERRUN_EN
  assign under = state == BFLY && !din_valid;
  always_ff @(posedge clk)
    if (!rstn) err <= 1'b0;
    else if (under) err <= 1'b1;
`else
  assign under = 1'b0;
  assign err = 1'b0;
`endif
  // cnt wraps to 0 by itself at DEPTH-1 because DEPTH is a power of two
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (din_valid) begin
          state <= FILL;
          cnt <= CW'(1);
        end
        FILL: if (din_valid) begin
          cnt <= cnt + CW'(1);
          if (last) state <= BFLY;
        end
        BFLY: if (under) begin
          state <= IDLE;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
          if (last) state <= DRAIN;
        end
        default: begin
          cnt <= cnt + CW'(1);
          if (last) state <= IDLE;
        end
      endcase
    end
  assign fill_in = state == IDLE || state == FILL;
  assign bfly_on = state == BFLY && !under;
  assign din_ready = state != DRAIN;
  assign sr_shift = fill_in ? din_valid : (bfly_on || state == DRAIN);
  assign sr_sel = state == BFLY;
  assign bfly_en = bfly_on;
  assign tw_addr = state == BFLY ? cnt[CW-1:CW-2] : 2'd0;
  assign out_sel = state == DRAIN;
  assign dout_valid = bfly_on || state == DRAIN;
  assign sof = bfly_on && cnt == '0;
  assign eof = state == DRAIN && last;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: directed and random stimulus against a frame-position reference model.
module tb_fft_stage_ctrl;
  localparam int D = 8;
`ifdef FFT_STAGE_CTRL_UNDERRUN_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0, din_valid = 1'b0;
  logic din_ready, sr_shift, sr_sel, bfly_en, out_sel, dout_valid, sof, eof, busy, err;
  logic [1:0] tw_addr;
  int total = 0, bad = 0, cyc_n = 0;
  int fill_n = 0, run_t = -1, err_m = 0;
  int sof_t[$];
  fft_stage_ctrl #(.DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_ready(din_ready),
    .sr_shift(sr_shift), .sr_sel(sr_sel), .bfly_en(bfly_en), .tw_addr(tw_addr),
    .out_sel(out_sel), .dout_valid(dout_valid), .sof(sof), .eof(eof), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc_n, obs, exp);
    end
  endtask
  // Model: fill_n = beats taken this frame before the butterfly starts, run_t = cycles since butterfly start.
  task automatic cyc(input logic v, input logic r);
    bit running, bph, drn, idle, und;
    @(negedge clk);
    din_valid = v;
    rstn = r;
    #1;
    running = run_t >= 0;
    bph = running && run_t < D;
    drn = running && run_t >= D;
    idle = !running && fill_n == 0;
    und = UEN && bph && !v;
    chk("din_ready", din_ready, !drn);
    chk("sr_shift", sr_shift, running ? !und : v);
    chk("sr_sel", sr_sel, bph);
    chk("bfly_en", bfly_en, bph && !und);
    chk("tw_addr", tw_addr, bph ? run_t / (D / 4) : 0);
    chk("out_sel", out_sel, drn);
    chk("dout_valid", dout_valid, running && !und);
    chk("sof", sof, run_t == 0 && !und);
    chk("eof", eof, run_t == 2 * D - 1);
    chk("busy", busy, !idle);
    chk("err", err, err_m);
    if (sof === 1'b1) sof_t.push_back(cyc_n);
    @(posedge clk);
    cyc_n++;
    if (!r) begin
      fill_n = 0;
      run_t = -1;
      err_m = 0;
    end else if (!running) begin
      if (v) fill_n++;
      if (fill_n == D) begin
        fill_n = 0;
        run_t = 0;
      end
    end else if (und) begin
      run_t = -1;
      err_m = 1;
    end else begin
      run_t++;
      if (run_t == 2 * D) run_t = -1;
    end
  endtask
  task automatic lat(input string tag, input int start, input int exp);
    chk(tag, sof_t.size() > 0 ? sof_t[0] - start : -1, exp);
  endtask
  initial begin
    int st;
    cyc(0, 0);
    cyc(0, 0);
    // continuous frame from reset release
    sof_t.delete();
    st = cyc_n;
    repeat (3 * D) cyc(1, 1);
    cyc(0, 1);
    lat("latency", st, D);
    chk("busy_end", busy, 0);
    // three-cycle stall at FILL cnt=4
    sof_t.delete();
    st = cyc_n;
    repeat (4) cyc(1, 1);
    repeat (3) cyc(0, 1);
    repeat (4 + 2 * D) cyc(1, 1);
    cyc(0, 1);
    lat("stall_latency", st, D + 3);
    // missing beat at BFLY cnt=5
    repeat (D + 5) cyc(1, 1);
    repeat (3 + D) cyc(0, 1);
    chk("err_hold", err, UEN ? 1 : 0);
    cyc(0, 0);
    cyc(0, 1);
    // reset at DRAIN cnt=3
    repeat (2 * D) cyc(1, 1);
    repeat (3) cyc(0, 1);
    cyc(0, 0);
    repeat (3) cyc(0, 1);
    // back-to-back frames
    sof_t.delete();
    repeat (6 * D) cyc(1, 1);
    cyc(0, 1);
    chk("b2b_gap", sof_t.size() > 1 ? sof_t[1] - sof_t[0] : -1, 3 * D);
    // random traffic with occasional resets
    repeat (600) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
